// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU / debug-host bus controller with RAM/IO decode, bus ownership FSM and posted IO write FIFO.
// Latency: RAM/IO strobes in the accept cycle, read data on cpu_din_out one cycle after accept.
// Backpressure: cpu_rdy_out low outside CPU ownership, on IO write with full FIFO, on IO read with non-empty FIFO.
// Optional feature macro: BUS_PERF_CNT_EN builds the CPU stall-cycle counter; otherwise perf_stall_out is 0.

module mem_bus_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int IO_FIFO_DEPTH  = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      cpu_en_in,
  input  logic                      cpu_wr_in,
  input  logic [ADDR_WIDTH-1:0]     cpu_a_in,
  input  logic [7:0]                cpu_dout_in,
  output logic [7:0]                cpu_din_out,
  output logic                      cpu_rdy_out,
  input  logic                      dbg_req_in,
  output logic                      dbg_gnt_out,
  input  logic                      dbg_wr_in,
  input  logic [RAM_ADDR_WIDTH-1:0] dbg_a_in,
  input  logic [7:0]                dbg_dout_in,
  output logic [7:0]                dbg_din_out,
  output logic                      ram_en_out,
  output logic                      ram_wr_out,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]                ram_d_out,
  input  logic [7:0]                ram_d_in,
  output logic                      io_en_out,
  output logic                      io_wr_out,
  output logic [IO_SEL_WIDTH-1:0]   io_sel_out,
  output logic [7:0]                io_d_out,
  input  logic [7:0]                io_d_in,
  input  logic                      io_full_in,
  output logic [31:0]               perf_stall_out
);

  localparam int PTR_W = $clog2(IO_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IO_SEL_WIDTH + 8;

  typedef enum logic [1:0] {
    ST_CPU_OWN = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DBG_OWN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ENT_W-1:0] r_fifo_mem [IO_FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_q_src_io;
  logic             r_rd_vld;

  logic             w_is_io;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_cpu_rdy;
  logic             w_acc;
  logic             w_ram_acc;
  logic             w_io_rd;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;
  logic             w_unused_a;

  // Address bits above the IO decode field carry no meaning for this bus.
  assign w_unused_a = ^cpu_a_in[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1];

  assign w_is_io      = (cpu_a_in[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(IO_FIFO_DEPTH));
  assign w_head       = r_fifo_mem[r_rd_ptr];

  // Readiness: IO reads wait for the FIFO to empty so they observe all earlier posted writes.
  always_comb begin
    w_cpu_rdy = 1'b0;
    if (r_state == ST_CPU_OWN) begin
      if (!w_is_io) begin
        w_cpu_rdy = 1'b1;
      end else if (cpu_wr_in) begin
        w_cpu_rdy = !w_fifo_full;
      end else begin
        w_cpu_rdy = w_fifo_empty;
      end
    end
  end

  assign w_acc     = cpu_en_in && w_cpu_rdy;
  assign w_ram_acc = w_acc && !w_is_io;
  assign w_io_rd   = w_acc && w_is_io && !cpu_wr_in;
  assign w_push    = w_acc && w_is_io && cpu_wr_in;
  assign w_pop     = !w_fifo_empty && !io_full_in && !w_io_rd;

  assign cpu_rdy_out = w_cpu_rdy;
  assign dbg_gnt_out = (r_state == ST_DBG_OWN);
  assign dbg_din_out = ram_d_in;
  assign cpu_din_out = r_rd_vld ? (r_q_src_io ? io_d_in : ram_d_in) : 8'h00;

  // Ownership state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_CPU_OWN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ownership next state: the debug host only gets the RAM once posted IO writes have drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CPU_OWN: if (dbg_req_in) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!dbg_req_in) begin
          w_state_nxt = ST_CPU_OWN;
        end else if (w_fifo_empty) begin
          w_state_nxt = ST_DBG_OWN;
        end
      end
      ST_DBG_OWN: if (!dbg_req_in) w_state_nxt = ST_CPU_OWN;
      default:    w_state_nxt = ST_CPU_OWN;
    endcase
  end

  // RAM and IO port muxing: debug host owns RAM in DBG_OWN, IO read beats a FIFO pop.
  always_comb begin
    ram_en_out = 1'b0;
    ram_wr_out = 1'b0;
    ram_a_out  = cpu_a_in[RAM_ADDR_WIDTH-1:0];
    ram_d_out  = cpu_dout_in;
    io_en_out  = 1'b0;
    io_wr_out  = 1'b0;
    io_sel_out = cpu_a_in[IO_SEL_WIDTH-1:0];
    io_d_out   = 8'h00;
    if (r_state == ST_DBG_OWN) begin
      ram_en_out = 1'b1;
      ram_wr_out = dbg_wr_in;
      ram_a_out  = dbg_a_in;
      ram_d_out  = dbg_dout_in;
    end else if (w_ram_acc) begin
      ram_en_out = 1'b1;
      ram_wr_out = cpu_wr_in;
    end
    if (w_io_rd) begin
      io_en_out = 1'b1;
    end else if (w_pop) begin
      io_en_out  = 1'b1;
      io_wr_out  = 1'b1;
      io_sel_out = w_head[ENT_W-1:8];
      io_d_out   = w_head[7:0];
    end
  end

  // FIFO storage: tail entry written on push; contents need no reset since the count gates use.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {cpu_a_in[IO_SEL_WIDTH-1:0], cpu_dout_in};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Read return source: remembers whether the accepted read went to IO or RAM.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_q_src_io <= 1'b0;
      r_rd_vld   <= 1'b0;
    end else begin
      r_q_src_io <= w_io_rd;
      r_rd_vld   <= (w_ram_acc && !cpu_wr_in) || w_io_rd;
    end
  end

`ifdef BUS_PERF_CNT_EN
  logic [31:0] r_perf_stall;

  // Stall counter: cycles the CPU requested but was not accepted, saturating.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_perf_stall <= 32'h0;
    end else if (cpu_en_in && !w_cpu_rdy && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_out = r_perf_stall;
`else
  assign perf_stall_out = 32'h0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: RAM/IO slave models, a queue-based reference of bus behaviour,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_mem_bus_ctrl;
  localparam int RAW   = 17;
  localparam int DEPTH = 4;
  localparam int OWN_CPU = 0, OWN_DRAIN = 1, OWN_DBG = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en_in, cpu_wr_in;
  logic [31:0] cpu_a_in;
  logic [7:0]  cpu_dout_in;
  logic [7:0]  cpu_din_out;
  logic        cpu_rdy_out;
  logic        dbg_req_in, dbg_gnt_out, dbg_wr_in;
  logic [16:0] dbg_a_in;
  logic [7:0]  dbg_dout_in, dbg_din_out;
  logic        ram_en_out, ram_wr_out;
  logic [16:0] ram_a_out;
  logic [7:0]  ram_d_out;
  logic [7:0]  ram_d_in = 8'h00;
  logic        io_en_out, io_wr_out;
  logic [2:0]  io_sel_out;
  logic [7:0]  io_d_out;
  logic [7:0]  io_d_in = 8'h00;
  logic        io_full_in;
  logic [31:0] perf_stall_out;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(RAW), .IO_SEL_WIDTH(3), .IO_FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .cpu_en_in(cpu_en_in), .cpu_wr_in(cpu_wr_in), .cpu_a_in(cpu_a_in), .cpu_dout_in(cpu_dout_in),
    .cpu_din_out(cpu_din_out), .cpu_rdy_out(cpu_rdy_out),
    .dbg_req_in(dbg_req_in), .dbg_gnt_out(dbg_gnt_out), .dbg_wr_in(dbg_wr_in), .dbg_a_in(dbg_a_in),
    .dbg_dout_in(dbg_dout_in), .dbg_din_out(dbg_din_out),
    .ram_en_out(ram_en_out), .ram_wr_out(ram_wr_out), .ram_a_out(ram_a_out), .ram_d_out(ram_d_out),
    .ram_d_in(ram_d_in),
    .io_en_out(io_en_out), .io_wr_out(io_wr_out), .io_sel_out(io_sel_out), .io_d_out(io_d_out),
    .io_d_in(io_d_in), .io_full_in(io_full_in), .perf_stall_out(perf_stall_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [31:0] v;
    v = i;
    if (v == 32'h100) return 8'hA5;
    return v[7:0] ^ v[15:8] ^ 8'h3C;
  endfunction

  // RAM and IO slaves with one-cycle read latency.
  logic [7:0] ram_mem [0:(1<<RAW)-1];
  logic [7:0] io_regs [0:7];
  logic       slave_init = 1'b0;
  always @(posedge clk) begin
    if (!slave_init) begin
      for (int i = 0; i < (1 << RAW); i++) ram_mem[i] <= pat(i);
      for (int i = 0; i < 8; i++) io_regs[i] <= 8'h00;
      slave_init <= 1'b1;
    end else begin
      if (ram_en_out) begin
        if (ram_wr_out) ram_mem[ram_a_out] <= ram_d_out;
        else            ram_d_in <= ram_mem[ram_a_out];
      end
      if (io_en_out) begin
        if (io_wr_out) io_regs[io_sel_out] <= io_d_out;
        else           io_d_in <= io_regs[io_sel_out];
      end
    end
  end

  // Reference model: ownership, queue of posted IO writes, expected memory/IO contents.
  int          m_owner;
  logic [10:0] m_q[$];
  int          m_rd_kind;
  logic [7:0]  m_rd_val;
  logic [31:0] m_perf;
  logic [7:0]  ref_mem [0:(1<<RAW)-1];
  logic [7:0]  ref_io [0:7];
  logic        model_init = 1'b0;

  always @(negedge clk) begin : cmp_p
    logic        is_io, rdy_e, acc, ioread, push, pop, ram_en_e, ram_wr_e;
    logic [16:0] ram_a_e;
    logic [7:0]  ram_d_e, din_e;
    logic [10:0] head;
    int          sz0;
    if (!model_init) begin
      for (int i = 0; i < (1 << RAW); i++) ref_mem[i] = pat(i);
      for (int i = 0; i < 8; i++) ref_io[i] = 8'h00;
      model_init = 1'b1;
    end
    if (!rst_n) begin
      m_owner = OWN_CPU; m_q.delete(); m_rd_kind = 0; m_perf = 32'h0;
    end
    sz0    = m_q.size();
    is_io  = (cpu_a_in[17:16] == 2'b11);
    rdy_e  = (m_owner == OWN_CPU) && (!is_io || (cpu_wr_in ? (sz0 < DEPTH) : (sz0 == 0)));
    acc    = cpu_en_in && rdy_e;
    ioread = acc && is_io && !cpu_wr_in;
    push   = acc && is_io && cpu_wr_in;
    pop    = (sz0 > 0) && !io_full_in && !ioread;
    head   = (sz0 > 0) ? m_q[0] : 11'h0;
    if (m_owner == OWN_DBG) begin
      ram_en_e = 1'b1; ram_wr_e = dbg_wr_in; ram_a_e = dbg_a_in; ram_d_e = dbg_dout_in;
    end else begin
      ram_en_e = acc && !is_io; ram_wr_e = ram_en_e && cpu_wr_in;
      ram_a_e = cpu_a_in[16:0]; ram_d_e = cpu_dout_in;
    end
    din_e = (m_rd_kind == 0) ? 8'h00 : m_rd_val;

    chk("cpu_rdy", {31'h0, cpu_rdy_out}, {31'h0, rdy_e});
    chk("dbg_gnt", {31'h0, dbg_gnt_out}, {31'h0, m_owner == OWN_DBG});
    chk("ram_en", {31'h0, ram_en_out}, {31'h0, ram_en_e});
    chk("ram_wr", {31'h0, ram_wr_out}, {31'h0, ram_wr_e});
    if (ram_en_e) chk("ram_a", {15'h0, ram_a_out}, {15'h0, ram_a_e});
    if (ram_wr_e) chk("ram_d", {24'h0, ram_d_out}, {24'h0, ram_d_e});
    chk("io_en", {31'h0, io_en_out}, {31'h0, ioread || pop});
    chk("io_wr", {31'h0, io_wr_out}, {31'h0, pop});
    if (ioread) chk("io_sel_rd", {29'h0, io_sel_out}, {29'h0, cpu_a_in[2:0]});
    if (pop) begin
      chk("io_sel_wr", {29'h0, io_sel_out}, {29'h0, head[10:8]});
      chk("io_d", {24'h0, io_d_out}, {24'h0, head[7:0]});
    end
    chk("cpu_din", {24'h0, cpu_din_out}, {24'h0, din_e});
    chk("dbg_din", {24'h0, dbg_din_out}, {24'h0, ram_d_in});
`ifdef BUS_PERF_CNT_EN
    chk("perf", perf_stall_out, m_perf);
`else
    chk("perf", perf_stall_out, 32'h0);
`endif

    if (rst_n) begin
      if (ram_en_e && ram_wr_e) ref_mem[ram_a_e] = ram_d_e;
      m_rd_kind = 0;
      if (acc && !is_io && !cpu_wr_in) begin m_rd_kind = 1; m_rd_val = ref_mem[cpu_a_in[16:0]]; end
      if (ioread) begin m_rd_kind = 2; m_rd_val = ref_io[cpu_a_in[2:0]]; end
      if (pop) begin ref_io[head[10:8]] = head[7:0]; void'(m_q.pop_front()); end
      if (push) m_q.push_back({cpu_a_in[2:0], cpu_dout_in});
      case (m_owner)
        OWN_CPU:   if (dbg_req_in) m_owner = OWN_DRAIN;
        OWN_DRAIN: if (!dbg_req_in) m_owner = OWN_CPU; else if (sz0 == 0) m_owner = OWN_DBG;
        default:   if (!dbg_req_in) m_owner = OWN_CPU;
      endcase
      if (cpu_en_in && !rdy_e && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_en_in = 1'b0; cpu_wr_in = 1'b0; cpu_a_in = 32'h0; cpu_dout_in = 8'h00;
    dbg_req_in = 1'b0; dbg_wr_in = 1'b0; dbg_a_in = 17'h0; dbg_dout_in = 8'h00; io_full_in = 1'b0;
  endtask

  task automatic cpu(input logic wr, input logic [31:0] a, input logic [7:0] d);
    cpu_en_in = 1'b1; cpu_wr_in = wr; cpu_a_in = a; cpu_dout_in = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {31'h0, dbg_gnt_out}, 32'h0);
    chk("rst_ram_en", {31'h0, ram_en_out}, 32'h0);
    chk("rst_io_en", {31'h0, io_en_out}, 32'h0);
    chk("rst_cpu_din", {24'h0, cpu_din_out}, 32'h0);
    chk("rst_perf", perf_stall_out, 32'h0);

    // RAM read of a preloaded location
    tick(); rst_n = 1'b1; cpu(1'b0, 32'h0000_0100, 8'h00);
    @(negedge clk);
    chk("lit_ram_rdy", {31'h0, cpu_rdy_out}, 32'h1);
    chk("lit_ram_en", {31'h0, ram_en_out}, 32'h1);
    chk("lit_ram_a", {15'h0, ram_a_out}, 32'h100);
    tick(); cpu_en_in = 1'b0;
    @(negedge clk);
    chk("lit_ram_rd", {24'h0, cpu_din_out}, 32'hA5);

    // Five IO writes against a full slave: four fit, the fifth stalls
    io_full_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); cpu(1'b1, 32'h0003_0000, 8'(8'h10 + k));
      @(negedge clk);
      chk("lit_iow_rdy", {31'h0, cpu_rdy_out}, (k < 4) ? 32'h1 : 32'h0);
    end
    tick(); cpu_en_in = 1'b0; io_full_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_pop_en", {30'h0, io_en_out, io_wr_out}, 32'h3);
      chk("lit_pop_d", {24'h0, io_d_out}, 32'h10 + k);
      tick();
    end
    @(negedge clk);
    chk("lit_pop_done", {31'h0, io_en_out}, 32'h0);

    // IO read must wait behind a posted IO write
    tick(); cpu(1'b1, 32'h0003_0004, 8'h77);
    @(negedge clk); chk("lit_w4_rdy", {31'h0, cpu_rdy_out}, 32'h1);
    tick(); cpu(1'b0, 32'h0003_0004, 8'h00);
    @(negedge clk);
    chk("lit_rd_stall", {31'h0, cpu_rdy_out}, 32'h0);
    chk("lit_rd_pop", {30'h0, io_en_out, io_wr_out}, 32'h3);
    tick();
    @(negedge clk);
    chk("lit_rd_rdy", {31'h0, cpu_rdy_out}, 32'h1);
    chk("lit_rd_strobe", {30'h0, io_en_out, io_wr_out}, 32'h2);
    chk("lit_rd_sel", {29'h0, io_sel_out}, 32'h4);
    tick(); cpu_en_in = 1'b0;
    @(negedge clk); chk("lit_io_rd", {24'h0, cpu_din_out}, 32'h77);

    // Debug request with two posted writes pending
    io_full_in = 1'b1;
    tick(); cpu(1'b1, 32'h0003_0001, 8'h21);
    tick(); cpu(1'b1, 32'h0003_0002, 8'h22);
    tick(); cpu_en_in = 1'b0; io_full_in = 1'b0; dbg_req_in = 1'b1;
    @(negedge clk); chk("lit_gnt_c0", {31'h0, dbg_gnt_out}, 32'h0);
    tick(); @(negedge clk); chk("lit_gnt_d1", {31'h0, dbg_gnt_out}, 32'h0);
    tick(); @(negedge clk); chk("lit_gnt_d2", {31'h0, dbg_gnt_out}, 32'h0);
    tick(); dbg_wr_in = 1'b1; dbg_a_in = 17'h1F000; dbg_dout_in = 8'h5A;
    @(negedge clk);
    chk("lit_gnt_on", {31'h0, dbg_gnt_out}, 32'h1);
    chk("lit_dbg_wr", {30'h0, ram_en_out, ram_wr_out}, 32'h3);
    chk("lit_dbg_a", {15'h0, ram_a_out}, 32'h1F000);
    tick(); dbg_wr_in = 1'b0;
    @(negedge clk); chk("lit_dbg_mem", {24'h0, ram_mem[17'h1F000]}, 32'h5A);
    tick(); @(negedge clk); chk("lit_dbg_din", {24'h0, dbg_din_out}, 32'h5A);

    // Dropping the request hands the bus back next cycle
    tick(); dbg_req_in = 1'b0;
    @(negedge clk); chk("lit_drop_gnt", {31'h0, dbg_gnt_out}, 32'h1);
    tick(); cpu(1'b0, 32'h0000_0105, 8'h00);
    @(negedge clk);
    chk("lit_back_gnt", {31'h0, dbg_gnt_out}, 32'h0);
    chk("lit_back_rdy", {31'h0, cpu_rdy_out}, 32'h1);

    // Reset in the middle of a drain discards the posted writes
    io_full_in = 1'b1;
    tick(); cpu(1'b1, 32'h0003_0003, 8'h31);
    tick(); cpu(1'b1, 32'h0003_0005, 8'h32);
    tick(); cpu_en_in = 1'b0; dbg_req_in = 1'b1;
    tick(); @(negedge clk); chk("lit_drain_gnt", {31'h0, dbg_gnt_out}, 32'h0);
    tick(); rst_n = 1'b0; idle();
    @(negedge clk);
    chk("lit_mrst_gnt", {31'h0, dbg_gnt_out}, 32'h0);
    chk("lit_mrst_io", {31'h0, io_en_out}, 32'h0);
    tick(); rst_n = 1'b1;
    @(negedge clk); chk("lit_mrst_nopop", {31'h0, io_en_out}, 32'h0);
    tick(); cpu(1'b0, 32'h0003_0003, 8'h00);
    @(negedge clk); chk("lit_mrst_rdrdy", {31'h0, cpu_rdy_out}, 32'h1);
    tick(); cpu_en_in = 1'b0;
    @(negedge clk); chk("lit_mrst_lost", {24'h0, cpu_din_out}, 32'h00);

    // Randomized traffic checked by the reference model
    for (int n = 0; n < 3000; n++) begin
      tick();
      r = $urandom;
      cpu_en_in   = ($urandom_range(0, 2) != 0);
      cpu_wr_in   = r[5];
      cpu_dout_in = 8'($urandom);
      if (r[6]) cpu_a_in = {r[31:18], 2'b11, 13'h0, r[2:0]};
      else      cpu_a_in = {r[31:18], 1'b0, r[4], 8'h01, 4'h0, r[3:0]};
      if ($urandom_range(0, 11) == 0) dbg_req_in = !dbg_req_in;
      dbg_wr_in   = r[7];
      dbg_a_in    = {13'h0100, r[11:8]};
      dbg_dout_in = 8'($urandom);
      io_full_in  = ($urandom_range(0, 2) == 0);
    end

    // Seven stalled request cycles while the debug host owns the bus
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; dbg_req_in = 1'b1;
    tick();
    repeat (7) begin tick(); cpu(1'b0, 32'h0000_0100, 8'h00); end
    tick(); cpu_en_in = 1'b0; dbg_req_in = 1'b0;
    @(negedge clk);
`ifdef BUS_PERF_CNT_EN
    chk("lit_perf7", perf_stall_out, 32'd7);
`else
    chk("lit_perf_off", perf_stall_out, 32'd0);
`endif
    tick(); idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
